mem_stage_dm: RTL and testbench
===============================

# mem_stage_dm

MEM-stage data memory for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It performs word, halfword and byte stores into a word-organised RAM. It returns a combinationally read, sign- or zero-extended load value, which the MEM/WB register captures as the MEM-stage memory data. It also emits a registered store-trace record for the grading log.

## Interface
- `ADDR_WIDTH`, default 12: word-index width; depth = 2^ADDR_WIDTH words (4096 words = 16 KiB).
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `storeOp` input 2: 0 none, 1 sw, 2 sh, 3 sb.
- `loadOp` input 3: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu; 5-7 behave as lw.
- `addr` input 32: byte address (ALU result from EX/MEM).
- `wData` input 32: store data (forwarded rt value); sh uses [15:0], sb uses [7:0].
- `pc` input 32: PC of the instruction in MEM, for tracing.
- `rData` output 32: extended load result, combinational.
- `traceValid` output 1: a store was committed on the previous edge.
- `tracePc` output 32: PC of that store.
- `traceAddr` output 32: word-aligned address of that store, `{addr[31:2],2'b00}`.
- `traceData` output 32: full word value written (merged word).

## Operation
- Word index `idx = addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo the depth.
- No misalignment detection:
  - sw/lw ignore `addr[1:0]`.
  - sh/lh/lhu ignore `addr[0]`; `addr[1]` selects the half (0 = [15:0], 1 = [31:16]).
  - sb/lb/lbu: `addr[1:0]` selects the byte (0 = [7:0] ... 3 = [31:24]).
- Merged word `mw` is the old word `mem[idx]` with the selected byte lanes replaced by store data. For sw, `mw = wData`.
- Store (`storeOp != 0`): at posedge, `mem[idx] <= mw`. Non-selected lanes are preserved.
- Load: `rData` is derived from current `mem[idx]` and `loadOp`.
  - lh and lb sign-extend.
  - lhu and lbu zero-extend.
  - `rData` is always driven; the consumer decides whether to use it.
- Trace register, updated at every posedge:
  - If a store occurs: `traceValid <= 1`, and `tracePc`, `traceAddr` and `traceData` take `pc`, the aligned address and `mw`.
  - Otherwise: `traceValid <= 0` and the other trace fields hold their values.

## Timing
- Write latency: 1 cycle. Data is visible on `rData` from the cycle after the edge.
- Read latency: 0 cycles (combinational from `addr`/`loadOp`).
- Same-cycle store and load to the same word: `rData` shows the pre-store contents. The new value appears after the edge.
- Back-to-back stores to the same word: the second merge uses the first store's result.
  - Example: sb lane 0, then sb lane 1, leaves both bytes updated.
- Trace outputs lag the store by exactly 1 cycle.
  - Consecutive stores produce `traceValid` high on consecutive cycles.
- Reset (synchronous):
  - At the edge with `reset = 1`, every memory word is set to 0.
  - `traceValid`, `tracePc`, `traceAddr` and `traceData` are set to 0.
  - A store presented in the same cycle as reset is discarded.
  - `rData` reads 0 from the next cycle onward.
- Reset mid-operation discards all stored data. No partial-clear state exists.

## Test plan
- **Reset clear:** sw 0xDEADBEEF to 0x10, then assert reset for 1 cycle; lw 0x10. Required: `rData = 0`, `traceValid = 0`, all trace fields 0.
- **Word store/load:** sw 0x12345678 to 0x0000_0004, pc 0x3000. Required: next cycle `traceValid = 1`, `tracePc = 0x3000`, `traceAddr = 0x4`, `traceData = 0x12345678`; lw 0x4 gives 0x12345678.
- **Byte lanes:** sw 0x11223344 to 0x8, then sb 0xAA to 0xB. Required: `traceData = 0xAA223344`.
  - lb 0xB gives 0xFFFFFFAA; lbu 0xB gives 0x000000AA; lb 0x8 gives 0x00000044.
- **Halfword:** sw 0 to 0xC, then sh 0x8001 to 0xE. Required: `traceData = 0x80010000`.
  - lh 0xE gives 0xFFFF8001; lhu 0xE gives 0x00008001; lh 0xC gives 0.
- **Read-before-write and wrap:** load 0x10 while storing 0x5555AAAA to 0x10. Required: `rData` shows the old value in that cycle and 0x5555AAAA the next cycle. Also, sw to 0x4010 (ADDR_WIDTH = 12) aliases word 0x10.
- **Store during reset and consecutive stores:** an sw in the reset cycle leaves memory 0 and `traceValid = 0`. Three back-to-back sb to 0x20/0x21/0x22 give `traceValid` high for 3 consecutive cycles with cumulative `traceData` values.

Source files
------------

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: byte/half/word stores, extended loads,
// and a registered store-trace record.
module mem_stage_dm #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  storeOp,
    input  logic [2:0]  loadOp,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    input  logic [31:0] pc,
    output logic [31:0] rData,
    output logic        traceValid,
    output logic [31:0] tracePc,
    output logic [31:0] traceAddr,
    output logic [31:0] traceData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           old_word;
    logic [31:0]           mw;
    logic [15:0]           half;
    logic [7:0]            byte_v;
    logic [4:0]            lane_sh;
    logic                  store;
    logic                  unused_addr_hi;

    assign idx            = addr[ADDR_WIDTH+1:2];
    assign old_word       = mem[idx];
    assign lane_sh        = {addr[1:0], 3'b000};
    assign store          = (storeOp != 2'd0);
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        mw = old_word;
        unique case (storeOp)
            2'd1: mw = wData;
            2'd2: begin
                if (addr[1]) mw[31:16] = wData[15:0];
                else         mw[15:0]  = wData[15:0];
            end
            2'd3: mw[lane_sh +: 8] = wData[7:0];
            default: ;
        endcase
    end

    assign half   = addr[1] ? old_word[31:16] : old_word[15:0];
    assign byte_v = old_word[lane_sh +: 8];

    always_comb begin
        rData = old_word;
        unique case (loadOp)
            3'd1: rData = {{16{half[15]}}, half};
            3'd2: rData = {16'h0, half};
            3'd3: rData = {{24{byte_v[7]}}, byte_v};
            3'd4: rData = {24'h0, byte_v};
            default: ;
        endcase
    end

    // Reset clears the whole array, so a store in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (store) begin
            mem[idx] <= mw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            traceValid <= 1'b0;
            tracePc    <= '0;
            traceAddr  <= '0;
            traceData  <= '0;
        end else begin
            traceValid <= store;
            if (store) begin
                tracePc   <= pc;
                traceAddr <= {addr[31:2], 2'b00};
                traceData <= mw;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_dm.sv
// Scoreboard bench for mem_stage_dm: stimulus queues expected
// load values and trace records, a negedge monitor checks them.
module tb_mem_stage_dm;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SW   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SB   = 2'd3;
    localparam logic [2:0] LD_LW   = 3'd0;
    localparam logic [2:0] LD_LH   = 3'd1;
    localparam logic [2:0] LD_LHU  = 3'd2;
    localparam logic [2:0] LD_LB   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  storeOp;
    logic [2:0]  loadOp;
    logic [31:0] addr;
    logic [31:0] wData;
    logic [31:0] pc;
    logic [31:0] rData;
    logic        traceValid;
    logic [31:0] tracePc;
    logic [31:0] traceAddr;
    logic [31:0] traceData;

    logic [31:0] rd_q [$];
    trace_t      tr_q [$];
    logic        rd_chk = 1'b0;
    logic        exp_tv = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_stage_dm #(.ADDR_WIDTH(12)) dut (
        .clk(clk),
        .reset(reset),
        .storeOp(storeOp),
        .loadOp(loadOp),
        .addr(addr),
        .wData(wData),
        .pc(pc),
        .rData(rData),
        .traceValid(traceValid),
        .tracePc(tracePc),
        .traceAddr(traceAddr),
        .traceData(traceData)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks traceValid every cycle, pops trace records when
    // the DUT presents one and pops load expectations when flagged.
    always @(negedge clk) begin
        trace_t t;
        check("traceValid", {31'b0, traceValid}, {31'b0, exp_tv});
        if (traceValid) begin
            if (tr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL trace_unexpected: got pc %h none expected",
                         tracePc);
            end else begin
                t = tr_q.pop_front();
                check("tracePc", tracePc, t.pc);
                check("traceAddr", traceAddr, t.addr);
                check("traceData", traceData, t.data);
            end
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_queue: got %h no expectation", rData);
            end else begin
                check("rData", rData, rd_q.pop_front());
            end
        end
        exp_tv = (storeOp != ST_NONE) && !reset;
    end

    task automatic step(input logic rst, input logic [1:0] so,
                        input logic [2:0] lo, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] p,
                        input logic chk, input logic [31:0] exp_rd);
        @(posedge clk);
        #1;
        reset   = rst;
        storeOp = so;
        loadOp  = lo;
        addr    = a;
        wData   = wd;
        pc      = p;
        rd_chk  = chk;
        if (chk) rd_q.push_back(exp_rd);
    endtask

    task automatic push_tr(input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] d);
        trace_t t;
        t.pc   = p;
        t.addr = a;
        t.data = d;
        tr_q.push_back(t);
    endtask

    task automatic ld(input logic [2:0] lo, input logic [31:0] a,
                      input logic [31:0] exp_rd);
        step(1'b0, ST_NONE, lo, a, 32'h0, 32'h0, 1'b1, exp_rd);
    endtask

    initial begin
        reset   = 1'b1;
        storeOp = ST_NONE;
        loadOp  = LD_LW;
        addr    = '0;
        wData   = '0;
        pc      = '0;
        step(1'b1, ST_NONE, LD_LW, 0, 0, 0, 1'b0, 0);
        step(1'b1, ST_NONE, LD_LW, 0, 0, 0, 1'b0, 0);

        // reset clear
        step(1'b0, ST_SW, LD_LW, 32'h10, 32'hDEADBEEF, 32'h100, 1'b0, 0);
        push_tr(32'h100, 32'h10, 32'hDEADBEEF);
        step(1'b1, ST_NONE, LD_LW, 0, 0, 0, 1'b0, 0);
        ld(LD_LW, 32'h10, 32'h0);
        check("rst_tracePc", tracePc, 32'h0);
        check("rst_traceAddr", traceAddr, 32'h0);
        check("rst_traceData", traceData, 32'h0);

        // word
        step(1'b0, ST_SW, LD_LW, 32'h4, 32'h12345678, 32'h3000, 1'b0, 0);
        push_tr(32'h3000, 32'h4, 32'h12345678);
        ld(LD_LW, 32'h4, 32'h12345678);

        // byte lanes
        step(1'b0, ST_SW, LD_LW, 32'h8, 32'h11223344, 32'h3004, 1'b0, 0);
        push_tr(32'h3004, 32'h8, 32'h11223344);
        step(1'b0, ST_SB, LD_LW, 32'hB, 32'h5A5A5AAA, 32'h3008, 1'b0, 0);
        push_tr(32'h3008, 32'h8, 32'hAA223344);
        ld(LD_LB, 32'hB, 32'hFFFFFFAA);
        ld(LD_LBU, 32'hB, 32'h000000AA);
        ld(LD_LB, 32'h8, 32'h00000044);
        ld(LD_LBU, 32'h9, 32'h00000033);

        // halfword
        step(1'b0, ST_SW, LD_LW, 32'hC, 32'h0, 32'h300C, 1'b0, 0);
        push_tr(32'h300C, 32'hC, 32'h0);
        step(1'b0, ST_SH, LD_LW, 32'hE, 32'hFFFF8001, 32'h3010, 1'b0, 0);
        push_tr(32'h3010, 32'hC, 32'h80010000);
        ld(LD_LH, 32'hE, 32'hFFFF8001);
        ld(LD_LHU, 32'hE, 32'h00008001);
        ld(LD_LH, 32'hC, 32'h0);

        // read-before-write, then wrap alias
        step(1'b0, ST_SW, LD_LW, 32'h10, 32'h5555AAAA, 32'h3014, 1'b1, 32'h0);
        push_tr(32'h3014, 32'h10, 32'h5555AAAA);
        ld(LD_LW, 32'h10, 32'h5555AAAA);
        step(1'b0, ST_SW, LD_LW, 32'h4010, 32'h77665544, 32'h3018, 1'b0, 0);
        push_tr(32'h3018, 32'h4010, 32'h77665544);
        ld(LD_LW, 32'h10, 32'h77665544);
        ld(LD_LH, 32'h12, 32'h00007766);

        // store during reset is dropped
        step(1'b1, ST_SW, LD_LW, 32'h20, 32'h99, 32'h3020, 1'b0, 0);
        ld(LD_LW, 32'h20, 32'h0);
        ld(LD_LW, 32'h10, 32'h0);

        // consecutive byte stores merge cumulatively
        step(1'b0, ST_SB, LD_LW, 32'h20, 32'h12345601, 32'h4000, 1'b0, 0);
        push_tr(32'h4000, 32'h20, 32'h00000001);
        step(1'b0, ST_SB, LD_LW, 32'h21, 32'hABCDEF02, 32'h4004, 1'b0, 0);
        push_tr(32'h4004, 32'h20, 32'h00000201);
        step(1'b0, ST_SB, LD_LW, 32'h22, 32'h00000003, 32'h4008, 1'b0, 0);
        push_tr(32'h4008, 32'h20, 32'h00030201);
        ld(LD_LW, 32'h20, 32'h00030201);
        ld(3'd5, 32'h20, 32'h00030201);
        ld(3'd7, 32'h23, 32'h00030201);

        step(1'b0, ST_NONE, LD_LW, 0, 0, 0, 1'b0, 0);
        step(1'b0, ST_NONE, LD_LW, 0, 0, 0, 1'b0, 0);
        @(negedge clk);
        #1;
        check("trace_q_left", tr_q.size(), 32'd0);
        check("rd_q_left", rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
